// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants and helpers for the fifo_flex FIFO.
//   FIFO_STD  : registered read mode (dout loads on an accepted read)
//   FIFO_FWFT : first-word-fall-through mode (head word shown on dout)
//   is_pow2   : elaboration-time check used on DEPTH
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// fifo_flex_if
// Producer/consumer side of the fifo_flex FIFO, grouped as one bundle.
//   master : user of the FIFO (drives wr_en/din/rd_en/clr_err)
//   slave  : the FIFO itself (drives data out, count and all flags)
interface fifo_flex_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int POINTER_WIDTH = $clog2(DEPTH);

    logic                     wr_en;
    logic [WIDTH-1:0]         din;
    logic                     full;
    logic                     almost_full;
    logic                     rd_en;
    logic [WIDTH-1:0]         dout;
    logic                     empty;
    logic                     almost_empty;
    logic [POINTER_WIDTH:0]   count;
    logic                     overflow;
    logic                     underflow;
    logic                     clr_err;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  full, almost_full, dout, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output full, almost_full, dout, empty, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flex_mem.sv
// fifo_flex_mem
// Storage array for fifo_flex: simple dual-port, synchronous write,
// asynchronous read, no reset (contents survive a FIFO reset).
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module fifo_flex_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, selectable read mode and sticky
// overflow/underflow flags.
//   clk : sole clock, rising edge
//   rst : asynchronous active-high reset
//   bus : fifo_flex_if.slave
//         in : wr_en, din, rd_en, clr_err
//         out: dout, full, almost_full, empty, almost_empty, count,
//              overflow, underflow
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int FWFT     = FIFO_STD,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic        clk,
    input  logic        rst,
    fifo_flex_if.slave  bus
);

    localparam int POINTER_WIDTH = $clog2(DEPTH);
    localparam int CW            = POINTER_WIDTH + 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_chk_depth
        $error("fifo_flex: DEPTH must be a power of two and at least 2");
    end
    if (AE_LEVEL < 1 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_chk_levels
        $error("fifo_flex: thresholds must satisfy 1 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_chk_mode
        $error("fifo_flex: FWFT must be 0 or 1");
    end

    logic [POINTER_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [POINTER_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q,  count_d;
    logic                     ovf_q,    ovf_d;
    logic                     udf_q,    udf_d;

    logic                     full;
    logic                     empty;
    logic                     wr_acc;
    logic                     rd_acc;
    logic [WIDTH-1:0]         mem_rdata;

    // Flags come straight from the registered count so they never glitch
    // on the request inputs.
    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    fifo_flex_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.din),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear first, then let a same-cycle error event override it.
        ovf_d = bus.clr_err ? 1'b0 : ovf_q;
        udf_d = bus.clr_err ? 1'b0 : udf_q;
        if (bus.wr_en && full)  ovf_d = 1'b1;
        if (bus.rd_en && empty) udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word shown directly; forced to zero while empty so the
        // output is clean during and after reset.
        assign bus.dout = empty ? '0 : mem_rdata;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) dout_d = mem_rdata;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) dout_q <= '0;
            else     dout_q <= dout_d;
        end

        assign bus.dout = dout_q;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.almost_empty = (count_q <= CNT_AE);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_flex.sv
module tb_fifo_flex;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fifo_flex_if #(.WIDTH(8), .DEPTH(8)) s_if ();
    fifo_flex_if #(.WIDTH(8), .DEPTH(8)) f_if ();

    fifo_flex #(
        .WIDTH(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)
    ) u_std (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    fifo_flex #(
        .WIDTH(8), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)
    ) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (f_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.din = 8'h00; s_if.clr_err = 1'b0;
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.din = 8'h00; f_if.clr_err = 1'b0;

        // ---- reset state ----
        step(); step();
        chk("rst_count", 32'(s_if.count), 0);
        chk("rst_empty", 32'(s_if.empty), 1);
        chk("rst_ae",    32'(s_if.almost_empty), 1);
        chk("rst_full",  32'(s_if.full), 0);
        chk("rst_af",    32'(s_if.almost_full), 0);
        chk("rst_ovf",   32'(s_if.overflow), 0);
        chk("rst_udf",   32'(s_if.underflow), 0);
        chk("rst_dout",  32'(s_if.dout), 0);
        rst = 1'b0;

        // ---- fill 0x01..0x08 ----
        for (int k = 1; k <= 8; k++) begin
            s_if.wr_en = 1'b1;
            s_if.din   = 8'(k);
            step();
            chk("fill_count", 32'(s_if.count), 32'(k));
            chk("fill_af",    32'(s_if.almost_full), (k >= 6) ? 1 : 0);
            chk("fill_ae",    32'(s_if.almost_empty), (k <= 2) ? 1 : 0);
            chk("fill_full",  32'(s_if.full), (k == 8) ? 1 : 0);
        end
        s_if.wr_en = 1'b0;

        // ---- drain ----
        for (int k = 1; k <= 8; k++) begin
            s_if.rd_en = 1'b1;
            step();
            chk("drain_dout",  32'(s_if.dout), 32'(k));
            chk("drain_count", 32'(s_if.count), 32'(8 - k));
        end
        s_if.rd_en = 1'b0;
        chk("drain_empty", 32'(s_if.empty), 1);
        step();
        chk("hold_dout", 32'(s_if.dout), 32'h08);

        // ---- wrap-around ----
        for (int k = 0; k < 5; k++) begin
            s_if.wr_en = 1'b1;
            s_if.din   = 8'(8'hE0 + k);
            step();
        end
        s_if.wr_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_if.rd_en = 1'b1;
            step();
            chk("pre_dout", 32'(s_if.dout), 32'(8'hE0 + k));
        end
        s_if.rd_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_if.wr_en = 1'b1;
            s_if.din   = 8'(8'h10 + k);
            step();
            chk("wrap_full", 32'(s_if.full), (k == 7) ? 1 : 0);
        end
        s_if.wr_en = 1'b0;

        // ---- simultaneous at full ----
        s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.din = 8'hAA;
        step();
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
        chk("sf_count", 32'(s_if.count), 7);
        chk("sf_ovf",   32'(s_if.overflow), 1);
        chk("sf_dout",  32'(s_if.dout), 32'h10);
        for (int k = 1; k < 8; k++) begin
            s_if.rd_en = 1'b1;
            step();
            chk("wrap_dout", 32'(s_if.dout), 32'(8'h10 + k));
        end
        s_if.rd_en = 1'b0;
        chk("wrap_empty", 32'(s_if.empty), 1);

        // ---- simultaneous at empty ----
        s_if.wr_en = 1'b1; s_if.rd_en = 1'b1; s_if.din = 8'h55;
        step();
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
        chk("se_count", 32'(s_if.count), 1);
        chk("se_udf",   32'(s_if.underflow), 1);
        chk("se_dout_hold", 32'(s_if.dout), 32'h17);
        s_if.rd_en = 1'b1;
        step();
        s_if.rd_en = 1'b0;
        chk("se_dout", 32'(s_if.dout), 32'h55);
        chk("se_count2", 32'(s_if.count), 0);

        // ---- clr_err ----
        s_if.clr_err = 1'b1;
        step();
        chk("clr_udf", 32'(s_if.underflow), 0);
        chk("clr_ovf", 32'(s_if.overflow), 0);
        s_if.rd_en = 1'b1;
        step();
        s_if.rd_en = 1'b0; s_if.clr_err = 1'b0;
        chk("clr_set_wins", 32'(s_if.underflow), 1);
        s_if.clr_err = 1'b1;
        step();
        s_if.clr_err = 1'b0;

        // ---- async reset mid-operation ----
        for (int k = 0; k < 9; k++) begin
            s_if.wr_en = 1'b1;
            s_if.din   = 8'(8'h30 + k);
            step();
        end
        s_if.wr_en = 1'b0;
        chk("pre_rst_ovf", 32'(s_if.overflow), 1);
        for (int k = 0; k < 3; k++) begin
            s_if.rd_en = 1'b1;
            step();
        end
        s_if.rd_en = 1'b0;
        chk("pre_rst_count", 32'(s_if.count), 5);
        chk("pre_rst_dout",  32'(s_if.dout), 32'h32);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(s_if.count), 0);
        chk("arst_empty", 32'(s_if.empty), 1);
        chk("arst_ovf",   32'(s_if.overflow), 0);
        chk("arst_dout",  32'(s_if.dout), 0);
        #1;
        rst = 1'b0;
        s_if.wr_en = 1'b1; s_if.din = 8'h77;
        step();
        s_if.wr_en = 1'b0;
        chk("post_rst_count", 32'(s_if.count), 1);
        s_if.rd_en = 1'b1;
        step();
        s_if.rd_en = 1'b0;
        chk("post_rst_dout", 32'(s_if.dout), 32'h77);

        // ---- FWFT ----
        chk("fw_empty0", 32'(f_if.empty), 1);
        f_if.wr_en = 1'b1; f_if.din = 8'h3C;
        step();
        f_if.wr_en = 1'b0;
        chk("fw_dout", 32'(f_if.dout), 32'h3C);
        chk("fw_nonempty", 32'(f_if.empty), 0);
        step();
        chk("fw_dout_hold", 32'(f_if.dout), 32'h3C);
        f_if.rd_en = 1'b1;
        step();
        f_if.rd_en = 1'b0;
        chk("fw_pop_empty", 32'(f_if.empty), 1);
        chk("fw_udf", 32'(f_if.underflow), 0);

        f_if.wr_en = 1'b1; f_if.din = 8'h01;
        step();
        for (int v = 2; v <= 32; v++) begin
            chk("fw_stream", 32'(f_if.dout), 32'(v - 1));
            f_if.wr_en = 1'b1; f_if.rd_en = 1'b1; f_if.din = 8'(v);
            step();
            chk("fw_stream_cnt", 32'(f_if.count), 1);
        end
        f_if.wr_en = 1'b0;
        chk("fw_last", 32'(f_if.dout), 32'h20);
        f_if.rd_en = 1'b1;
        step();
        f_if.rd_en = 1'b0;
        chk("fw_end_empty", 32'(f_if.empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised synchronous FIFO; next generation of the lab's basic FIFO.
- Adds over the basic FIFO:
  - occupancy count output
  - programmable almost-full / almost-empty thresholds
  - selectable read mode: standard registered read, or first-word-fall-through (FWFT)
  - sticky overflow / underflow error flags
- Sits between producer/consumer blocks in the same clock domain, e.g. UART RX/TX buffering and memory-request queues.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 32: number of entries; must be a power of two and ≥ 2.
- POINTER_WIDTH, $clog2(DEPTH): read/write pointer width; derived, never overridden.
- FWFT, 0: 0 = standard read, 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- rd_en  in  1  read request (standard) or pop/acknowledge (FWFT).
- dout  out  WIDTH  read data.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  POINTER_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by a write attempt while full.
- underflow  out  1  sticky; set by a read attempt while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values, applied immediately on rst assertion, independent of clk, including mid-transfer:
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - overflow = underflow = 0, dout = 0
  - memory contents are not cleared.
  - First accepted write is possible on the first rising edge after rst deasserts.
- Write acceptance:
  - wr_acc = wr_en && !full.
  - On accept: mem[wr_ptr] <= din; wr_ptr increments and wraps DEPTH-1 → 0 by natural overflow.
- Read acceptance:
  - rd_acc = rd_en && !empty.
  - On accept: rd_ptr increments with the same wrap rule.
- Count update:
  - +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
  - All flags are derived combinationally from the registered count.
- Simultaneous read and write:
  - When full: the write is refused even though a read is accepted the same cycle. Count goes DEPTH → DEPTH-1 and overflow sets.
  - When empty: the read is refused and the write is accepted. Count goes 0 → 1 and underflow sets.
  - Otherwise both are accepted; count is unchanged and data order is preserved.
- Standard mode (FWFT=0):
  - dout is a register loaded with mem[rd_ptr] on the edge where rd_acc is true.
  - Read latency is 1 cycle from the rd_en sample to valid dout.
  - dout holds its value when there is no accepted read, including after the FIFO goes empty.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] continuously; valid whenever empty = 0.
  - A written word appears on dout the cycle after its write edge (same cycle empty falls).
  - rd_acc pops the word, and the next word is visible the cycle after.
  - dout is undefined while empty and must not be checked then.
- Error flags:
  - overflow <= 1 on wr_en && full; underflow <= 1 on rd_en && empty.
  - Both clear on clr_err. A set event in the same cycle as clr_err wins (flag stays 1).
  - A refused request never changes pointers, count or memory.
- Elaboration-time checks: DEPTH is a power of two, 1 ≤ AE_LEVEL < AF_LEVEL ≤ DEPTH, FWFT ∈ {0,1}. A violation causes $error.

Decomposition:
- Package fifo_pkg:
  - localparam read-mode constants FIFO_STD = 0, FIFO_FWFT = 1
  - helper function is_pow2
- Sub-module fifo_flex_mem:
  - simple dual-port array with WIDTH and DEPTH parameters
  - synchronous write port, asynchronous read port
  - no reset
  - owns only storage.
- fifo_flex keeps pointers, count, flags and the dout register / bypass.

Test Plan:
- Fill/drain, WIDTH=8, DEPTH=8, FWFT=0:
  - Write 0x01..0x08 on consecutive cycles → full=1 after the 8th edge, count=8, almost_full from count=6.
  - Then rd_en for 8 cycles → dout 0x01..0x08, one cycle after each rd_en; empty=1 after the last; count=0.
- Wrap-around:
  - Write 5, read 5, then write 0x10..0x17 and read all 8 → output order 0x10..0x17 intact across pointer wrap.
  - full asserts exactly at count=8.
- Boundary simultaneity:
  - At full, assert wr_en+rd_en with din=0xAA → count 8→7, overflow=1, 0xAA never read out.
  - At empty, assert wr_en+rd_en with din=0x55 → count 0→1, underflow=1, 0x55 read next.
- FWFT=1:
  - Write 0x3C into empty FIFO → dout=0x3C and empty=0 on the cycle after the write edge, with no rd_en.
  - rd_en pops it → empty=1.
  - Back-to-back write/pop stream of 0x01..0x20 → every value observed once, in order.
- Async reset mid-operation:
  - With count=5 and overflow set, pulse rst between clock edges → count=0, empty=1, overflow=0, dout=0 before the next edge.
  - A write on the first edge after release → count=1.
- clr_err:
  - Set underflow, then assert clr_err alone → underflow=0 next cycle.
  - Assert clr_err with rd_en while empty → underflow remains 1.
